// File: rtl/screen_buffer_responder.sv
// screen_buffer_responder: responder side of the screen-region protocol.
// Raster-scans a requested region over an on-chip framebuffer, presents each
// pixel's coordinates and stored colour, and writes back the returned colour.
// A separate scan-out port reads the buffer independently of the scan FSM.
module screen_buffer_responder #(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    screen_start,
  input  logic [WIDTH-1:0]        screen_x_min,
  input  logic [WIDTH-1:0]        screen_y_min,
  input  logic [WIDTH-1:0]        screen_x_range,
  input  logic [WIDTH-1:0]        screen_y_range,
  input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
  output logic [WIDTH-1:0]        screen_x,
  output logic [WIDTH-1:0]        screen_y,
  output logic [COLOUR_WIDTH-1:0] old_screen_colour,
  output logic                    screen_done,
  input  logic [WIDTH-1:0]        rd_x,
  input  logic [WIDTH-1:0]        rd_y,
  output logic [COLOUR_WIDTH-1:0] rd_colour
);

  localparam int DEPTH = SCREEN_W * SCREEN_H;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] SW_U  = WIDTH'(SCREEN_W);
  localparam logic signed [WIDTH-1:0] SW_S = WIDTH'(SCREEN_W);
  localparam logic signed [WIDTH-1:0] SH_S = WIDTH'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CMP, S_DONE} state_t;

  // Signed bounds check; negative coordinates are caught by their sign bit.
  function automatic logic on_screen(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return !x[WIDTH-1] && ($signed(x) < SW_S) && !y[WIDTH-1] && ($signed(y) < SH_S);
  endfunction

  // Row-major address; only meaningful for on-screen coordinates.
  function automatic logic [AW-1:0] addr_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return AW'(y * SW_U + x);
  endfunction

  logic [COLOUR_WIDTH-1:0] mem_q [DEPTH];

  state_t                  state_q;
  logic [WIDTH-1:0]        x_min_q, x_end_q, y_end_q;
  logic [WIDTH-1:0]        screen_x_q, screen_y_q;
  logic [COLOUR_WIDTH-1:0] old_q, rd_colour_q;
  logic                    done_q;

  logic [WIDTH-1:0] nx_d, ny_d;
  logic             last_d, cur_on, wr_en, rd_on;
  logic [AW-1:0]    cur_addr, rd_addr;

  // Next raster position, end-of-region detect and write qualification.
  // The screen_x/screen_y registers double as the scan cursor.
  always_comb begin
    nx_d     = screen_x_q + ONE;
    ny_d     = screen_y_q;
    last_d   = (screen_x_q == x_end_q) && (screen_y_q == y_end_q);
    cur_on   = on_screen(screen_x_q, screen_y_q);
    cur_addr = addr_of(screen_x_q, screen_y_q);
    rd_on    = on_screen(rd_x, rd_y);
    rd_addr  = addr_of(rd_x, rd_y);
    if (screen_x_q == x_end_q) begin
      nx_d = x_min_q;
      ny_d = screen_y_q + ONE;
    end
    // Reset on the write edge aborts the pixel in flight.
    wr_en = (state_q == S_CMP) && cur_on && !reset;
  end

  // Region scan FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_min_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      screen_x_q <= '0;
      screen_y_q <= '0;
      old_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (screen_start) begin
            x_min_q <= screen_x_min;
            x_end_q <= screen_x_min + screen_x_range - ONE;
            y_end_q <= screen_y_min + screen_y_range - ONE;
            if (screen_x_range == '0 || screen_y_range == '0) begin
              // Zero-area region: presented coordinates keep their old values.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_ADDR;
              screen_x_q <= screen_x_min;
              screen_y_q <= screen_y_min;
            end
          end
        end
        S_ADDR: begin
          old_q   <= cur_on ? mem_q[cur_addr] : '0;
          state_q <= S_CMP;
        end
        S_CMP: begin
          if (last_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_ADDR;
            screen_x_q <= nx_d;
            screen_y_q <= ny_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Framebuffer write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[cur_addr] <= new_screen_colour;
  end

  // Scan-out read port; sees pre-write data on a same-cycle address hit.
  always_ff @(posedge clock) begin
    if (reset) rd_colour_q <= '0;
    else       rd_colour_q <= rd_on ? mem_q[rd_addr] : '0;
  end

  assign screen_x          = screen_x_q;
  assign screen_y          = screen_y_q;
  assign old_screen_colour = old_q;
  assign screen_done       = done_q;
  assign rd_colour         = rd_colour_q;

endmodule

// File: tb/tb_screen_buffer_responder.sv
// Directed bench for screen_buffer_responder: a model initiator returns either
// a fixed colour or old+1; regions are run with cycle-accurate sampling.
module tb_screen_buffer_responder;

  logic        clock = 1'b0;
  logic        reset, screen_start;
  logic [31:0] screen_x_min, screen_y_min, screen_x_range, screen_y_range;
  logic [2:0]  new_screen_colour;
  logic [31:0] screen_x, screen_y;
  logic [2:0]  old_screen_colour;
  logic        screen_done;
  logic [31:0] rd_x, rd_y;
  logic [2:0]  rd_colour;

  logic        inc_mode;
  logic [2:0]  fill_col;

  always #5 clock = ~clock;

  screen_buffer_responder dut (
    .clock(clock), .reset(reset), .screen_start(screen_start),
    .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
    .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
    .new_screen_colour(new_screen_colour),
    .screen_x(screen_x), .screen_y(screen_y),
    .old_screen_colour(old_screen_colour), .screen_done(screen_done),
    .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour)
  );

  assign new_screen_colour = inc_mode ? 3'(old_screen_colour + 3'd1) : fill_col;

  int total = 0, bad = 0;
  int ndone, dcyc, npix;
  int px [64];
  int py [64];
  int po [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic chk_rd(input string tag, input int x, input int y, input int exp);
    @(negedge clock);
    rd_x = x; rd_y = y;
    @(negedge clock);
    chk(tag, 32'(rd_colour), exp);
  endtask

  task automatic chk_pix(input int i, input int x, input int y, input int o);
    chk($sformatf("pix%0d_x", i), px[i], x);
    chk($sformatf("pix%0d_y", i), py[i], y);
    chk($sformatf("pix%0d_old", i), po[i], o);
  endtask

  // Start a region and sample cycles 1..lim after the start edge at negedge.
  // glitch: cycle in which a stray screen_start is raised; rst_at: cycle in
  // which reset is raised (0 = never). CMP cycles are the even ones.
  task automatic run_region(input int xm, input int ym, input int xr, input int yr,
                            input int lim, input int glitch, input int rst_at);
    @(negedge clock);
    screen_x_min = xm; screen_y_min = ym;
    screen_x_range = xr; screen_y_range = yr;
    screen_start = 1'b1;
    @(negedge clock);
    screen_start = 1'b0;
    ndone = 0; dcyc = 0; npix = 0;
    for (int k = 1; k <= lim; k++) begin
      if (k > 1) @(negedge clock);
      if (k == rst_at) reset = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) reset = 1'b0;
      if (k == glitch) screen_start = 1'b1;
      if (glitch != 0 && k == glitch + 1) screen_start = 1'b0;
      if (screen_done) begin
        ndone++;
        if (dcyc == 0) dcyc = k;
      end else if (k % 2 == 0 && dcyc == 0 && npix < 64 && (rst_at == 0 || k < rst_at)) begin
        px[npix] = $signed(screen_x);
        py[npix] = $signed(screen_y);
        po[npix] = int'(old_screen_colour);
        npix++;
      end
    end
    reset = 1'b0;
    screen_start = 1'b0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; screen_start = 1'b0;
    screen_x_min = '0; screen_y_min = '0; screen_x_range = '0; screen_y_range = '0;
    rd_x = '0; rd_y = '0; inc_mode = 1'b0; fill_col = 3'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("rst_done", 32'(screen_done), 0);
    chk("rst_x", screen_x, 0);
    chk("rst_y", screen_y, 0);
    chk("rst_old", 32'(old_screen_colour), 0);
    chk("rst_rd", 32'(rd_colour), 0);

    // Zero the whole framebuffer through the protocol itself.
    run_region(0, 0, 160, 120, 38403, 0, 0);
    chk("init_dcyc", dcyc, 38401);
    chk("init_ndone", ndone, 1);
    chk_rd("rd_0_0", 0, 0, 0);
    chk_rd("rd_159_119", 159, 119, 0);

    // 2x2 fill with colour 5.
    fill_col = 3'd5;
    run_region(2, 3, 2, 2, 12, 0, 0);
    chk("t1_dcyc", dcyc, 9);
    chk("t1_ndone", ndone, 1);
    chk("t1_npix", npix, 4);
    chk_pix(0, 2, 3, 0);
    chk_pix(1, 3, 3, 0);
    chk_pix(2, 2, 4, 0);
    chk_pix(3, 3, 4, 0);
    chk_rd("t1_rd_3_4", 3, 4, 5);
    chk_rd("t1_rd_4_4", 4, 4, 0);
    chk_rd("t1_rd_2_3", 2, 3, 5);

    // Same region, initiator returns old+1.
    inc_mode = 1'b1;
    run_region(2, 3, 2, 2, 12, 0, 0);
    inc_mode = 1'b0;
    chk("t2_dcyc", dcyc, 9);
    chk("t2_npix", npix, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_old%0d", i), po[i], 5);
    chk_rd("t2_rd_2_3", 2, 3, 6);
    chk_rd("t2_rd_3_4", 3, 4, 6);

    // Region straddling the left and bottom edges.
    fill_col = 3'd3;
    run_region(-1, 118, 3, 3, 22, 0, 0);
    chk("t3_dcyc", dcyc, 19);
    chk("t3_ndone", ndone, 1);
    chk("t3_npix", npix, 9);
    for (int i = 0; i < 9; i++) chk_pix(i, -1 + i % 3, 118 + i / 3, 0);
    chk_rd("t3_rd_0_118", 0, 118, 3);
    chk_rd("t3_rd_1_118", 1, 118, 3);
    chk_rd("t3_rd_0_119", 0, 119, 3);
    chk_rd("t3_rd_1_119", 1, 119, 3);
    chk_rd("t3_rd_2_118", 2, 118, 0);
    chk_rd("t3_rd_159_118", 159, 118, 0);
    chk_rd("t3_rd_159_119", 159, 119, 0);
    chk_rd("t3_rd_offscr", 160, 117, 0);

    // Zero-area region; presented coordinates hold.
    run_region(5, 5, 0, 4, 4, 0, 0);
    chk("t4_dcyc", dcyc, 1);
    chk("t4_ndone", ndone, 1);
    chk("t4_npix", npix, 0);
    chk("t4_hold_x", screen_x, 1);
    chk("t4_hold_y", screen_y, 120);
    chk_rd("t4_rd_5_5", 5, 5, 0);

    // Stray start while busy is ignored.
    fill_col = 3'd2;
    run_region(10, 10, 2, 2, 14, 3, 0);
    chk("t5_dcyc", dcyc, 9);
    chk("t5_ndone", ndone, 1);
    chk_rd("t5_rd_11_11", 11, 11, 2);

    // Reset in the third pixel's CMP cycle.
    fill_col = 3'd6;
    run_region(20, 20, 2, 2, 12, 0, 6);
    chk("t6_ndone", ndone, 0);
    chk("t6_x", screen_x, 0);
    chk_rd("t6_rd_20_20", 20, 20, 6);
    chk_rd("t6_rd_21_20", 21, 20, 6);
    chk_rd("t6_rd_20_21", 20, 21, 0);
    chk_rd("t6_rd_21_21", 21, 21, 0);
    run_region(0, 0, 0, 1, 3, 0, 0);
    chk("t6_idle_dcyc", dcyc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
